// File: rtl/i2c_sys_defines.sv
// Shared definitions for the I2C target model.
//   state_e        : 4-bit FSM encoding ST_S_IDLE..ST_S_RDATA_ACK
//   RD / WR        : value of the R/W bit in the address byte
//   DEF_SLAVE_ADDR : default 7-bit device address
package i2c_sys_defines;

    typedef enum logic [3:0] {
        ST_S_IDLE      = 4'd0,
        ST_S_ADDR      = 4'd1,
        ST_S_ADDR_ACK  = 4'd2,
        ST_S_PTR       = 4'd3,
        ST_S_PTR_ACK   = 4'd4,
        ST_S_WDATA     = 4'd5,
        ST_S_WDATA_ACK = 4'd6,
        ST_S_RDATA     = 4'd7,
        ST_S_RDATA_ACK = 4'd8
    } state_e;

    localparam logic       RD             = 1'b1;
    localparam logic       WR             = 1'b0;
    localparam logic [6:0] DEF_SLAVE_ADDR = 7'h10;

endpackage

// File: rtl/i2c_slave_sync.sv
// Synchronizer and bus-condition detector for SCL/SDA.
//   clk, rst          : system clock, async active-high reset
//   scl_i, sda_i      : asynchronous pad inputs
//   scl_rise/scl_fall : one-clk pulses on synchronized SCL edges
//   start_det/stop_det: one-clk pulses on START / STOP conditions
//   sda_s             : synchronized SDA, aligned with the pulses above
// Pulses appear 3 clk after the pad edge (2 sync flops + registered detect).
module i2c_slave_sync (
    input  logic clk,
    input  logic rst,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_s
);
    // [0],[1] synchronize; [2] is the previous synchronized value
    logic [2:0] scl_sync_q, sda_sync_q;
    logic       scl_rise_q, scl_fall_q, start_q, stop_q;
    logic       scl_rise_d, scl_fall_d, start_d, stop_d;
    logic       scl_hi;

    always_comb begin
        scl_hi     = scl_sync_q[1] & scl_sync_q[2];
        scl_rise_d = scl_sync_q[1] & ~scl_sync_q[2];
        scl_fall_d = ~scl_sync_q[1] & scl_sync_q[2];
        start_d    = scl_hi & sda_sync_q[2] & ~sda_sync_q[1];
        stop_d     = scl_hi & ~sda_sync_q[2] & sda_sync_q[1];
    end

    // Reset to the idle-bus level so no edge is seen on reset release
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync_q <= 3'b111;
            sda_sync_q <= 3'b111;
            scl_rise_q <= 1'b0;
            scl_fall_q <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
        end else begin
            scl_sync_q <= {scl_sync_q[1:0], scl_i};
            sda_sync_q <= {sda_sync_q[1:0], sda_i};
            scl_rise_q <= scl_rise_d;
            scl_fall_q <= scl_fall_d;
            start_q    <= start_d;
            stop_q     <= stop_d;
        end
    end

    assign scl_rise  = scl_rise_q;
    assign scl_fall  = scl_fall_q;
    assign start_det = start_q;
    assign stop_det  = stop_q;
    // sda_sync_q[2] now equals the sample taken alongside the edge just registered
    assign sda_s     = sda_sync_q[2];

endmodule

// File: rtl/i2c_slave_mem.sv
// I2C target with a 2**MEM_AW byte register file.
//   clk, rst      : system clock (>= 8x SCL), async active-high reset
//   scl_i, sda_i  : pad inputs;  sda_oe : 1 pulls SDA low
//   host_*        : local preload port, host_rdata = mem[host_addr]
//   bus_wr*       : one-clk commit pulse with index/data of a bus write
//   busy          : addressed START until STOP
// Build option I2C_SLAVE_AUTOINC_EN: pointer advances after each written
// byte and each ACKed read byte; otherwise it stays fixed per transaction.
module i2c_slave_mem
    import i2c_sys_defines::*;
#(
    parameter logic [6:0] SLAVE_ADDR = DEF_SLAVE_ADDR,
    parameter int         MEM_AW     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scl_i,
    input  logic              sda_i,
    output logic              sda_oe,
    input  logic              host_we,
    input  logic [MEM_AW-1:0] host_addr,
    input  logic [7:0]        host_wdata,
    output logic [7:0]        host_rdata,
    output logic              bus_wr,
    output logic [MEM_AW-1:0] bus_wr_addr,
    output logic [7:0]        bus_wr_data,
    output logic              busy
);
    localparam int DEPTH = 2 ** MEM_AW;
`ifdef I2C_SLAVE_AUTOINC_EN
    localparam logic [MEM_AW-1:0] PTR_STEP = MEM_AW'(1);
`else
    localparam logic [MEM_AW-1:0] PTR_STEP = MEM_AW'(0);
`endif

    logic scl_rise, scl_fall, start_det, stop_det, sda_s;

    i2c_slave_sync u_sync (
        .clk       (clk),
        .rst       (rst),
        .scl_i     (scl_i),
        .sda_i     (sda_i),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det),
        .sda_s     (sda_s)
    );

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;          // SCL rises seen in this byte
    logic [7:0]        sr_q, sr_d;            // receive shift register
    logic [7:0]        tx_q, tx_d;            // transmit shift register
    logic [MEM_AW-1:0] ptr_q, ptr_d, ptr_nxt;
    logic              ack_q, ack_d;          // master ACK/NACK after a read
    logic              sda_oe_q, sda_oe_d;
    logic              busy_q, busy_d;
    logic              bus_wr_q, bus_wr_d;
    logic [MEM_AW-1:0] bus_wr_addr_q, bus_wr_addr_d;
    logic [7:0]        bus_wr_data_q, bus_wr_data_d;
    logic [7:0]        mem_q [DEPTH];

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        sr_d          = sr_q;
        tx_d          = tx_q;
        ptr_d         = ptr_q;
        ack_d         = ack_q;
        sda_oe_d      = sda_oe_q;
        busy_d        = busy_q;
        bus_wr_d      = 1'b0;
        bus_wr_addr_d = bus_wr_addr_q;
        bus_wr_data_d = bus_wr_data_q;
        ptr_nxt       = ptr_q + PTR_STEP;

        if (stop_det) begin
            state_d  = ST_S_IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else if (start_det) begin
            state_d  = ST_S_ADDR;
            cnt_d    = '0;
            sda_oe_d = 1'b0;
        end else if (scl_rise) begin
            case (state_q)
                ST_S_ADDR, ST_S_PTR, ST_S_WDATA: begin
                    sr_d  = {sr_q[6:0], sda_s};
                    cnt_d = cnt_q + 4'd1;
                end
                ST_S_RDATA:     cnt_d = cnt_q + 4'd1;
                ST_S_RDATA_ACK: ack_d = sda_s;
                default: ;
            endcase
        end else if (scl_fall) begin
            // All SDA changes happen here, inside the SCL low phase
            case (state_q)
                ST_S_ADDR: if (cnt_q == 4'd8) begin
                    if (sr_q[7:1] == SLAVE_ADDR && sr_q[7:1] != 7'h00) begin
                        state_d  = ST_S_ADDR_ACK;
                        sda_oe_d = 1'b1;
                        busy_d   = 1'b1;
                    end else begin
                        state_d  = ST_S_IDLE;
                        sda_oe_d = 1'b0;
                        busy_d   = 1'b0;
                    end
                end
                ST_S_ADDR_ACK: begin
                    cnt_d = '0;
                    if (sr_q[0] == RD) begin
                        state_d  = ST_S_RDATA;
                        tx_d     = mem_q[ptr_q];
                        sda_oe_d = ~mem_q[ptr_q][7];
                    end else begin
                        state_d  = ST_S_PTR;
                        sda_oe_d = 1'b0;
                    end
                end
                ST_S_PTR: if (cnt_q == 4'd8) begin
                    state_d  = ST_S_PTR_ACK;
                    sda_oe_d = 1'b1;
                    ptr_d    = sr_q[MEM_AW-1:0];
                end
                ST_S_WDATA: if (cnt_q == 4'd8) begin
                    state_d       = ST_S_WDATA_ACK;
                    sda_oe_d      = 1'b1;
                    bus_wr_d      = 1'b1;
                    bus_wr_addr_d = ptr_q;
                    bus_wr_data_d = sr_q;
                    ptr_d         = ptr_nxt;
                end
                ST_S_PTR_ACK, ST_S_WDATA_ACK: begin
                    state_d  = ST_S_WDATA;
                    cnt_d    = '0;
                    sda_oe_d = 1'b0;
                end
                ST_S_RDATA: begin
                    if (cnt_q == 4'd8) begin
                        state_d  = ST_S_RDATA_ACK;
                        sda_oe_d = 1'b0;
                    end else begin
                        tx_d     = {tx_q[6:0], 1'b0};
                        sda_oe_d = ~tx_q[6];
                    end
                end
                ST_S_RDATA_ACK: begin
                    if (!ack_q) begin
                        state_d  = ST_S_RDATA;
                        cnt_d    = '0;
                        ptr_d    = ptr_nxt;
                        tx_d     = mem_q[ptr_nxt];
                        sda_oe_d = ~mem_q[ptr_nxt][7];
                    end else begin
                        state_d  = ST_S_IDLE;
                        sda_oe_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_S_IDLE;
            cnt_q         <= '0;
            sr_q          <= '0;
            tx_q          <= '0;
            ptr_q         <= '0;
            ack_q         <= 1'b1;
            sda_oe_q      <= 1'b0;
            busy_q        <= 1'b0;
            bus_wr_q      <= 1'b0;
            bus_wr_addr_q <= '0;
            bus_wr_data_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            sr_q          <= sr_d;
            tx_q          <= tx_d;
            ptr_q         <= ptr_d;
            ack_q         <= ack_d;
            sda_oe_q      <= sda_oe_d;
            busy_q        <= busy_d;
            bus_wr_q      <= bus_wr_d;
            bus_wr_addr_q <= bus_wr_addr_d;
            bus_wr_data_q <= bus_wr_data_d;
        end
    end

    // Bus write is issued last so it overrides a same-index host write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (host_we)  mem_q[host_addr]     <= host_wdata;
            if (bus_wr_d) mem_q[bus_wr_addr_d] <= bus_wr_data_d;
        end
    end

    assign host_rdata  = mem_q[host_addr];
    assign sda_oe      = sda_oe_q;
    assign busy        = busy_q;
    assign bus_wr      = bus_wr_q;
    assign bus_wr_addr = bus_wr_addr_q;
    assign bus_wr_data = bus_wr_data_q;

endmodule

// File: tb/tb_i2c_slave_mem.sv
// Directed bench for i2c_slave_mem: bit-banged I2C master, bus-write
// scoreboard fed at stimulus time and drained by a bus_wr monitor.
module tb_i2c_slave_mem;
    localparam int Q = 8;   // clk per quarter SCL period

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl_m = 1'b1, sda_m = 1'b1;
    logic       sda_oe, bus_wr, busy, host_we = 1'b0;
    logic [3:0] host_addr = '0, bus_wr_addr;
    logic [7:0] host_wdata = '0, host_rdata, bus_wr_data;
    wire        sda_line = sda_m & ~sda_oe;

    int n_vec = 0;
    int n_err = 0;
    logic [11:0] exp_q[$];

    always #5 clk = ~clk;

    i2c_slave_mem dut (
        .clk         (clk),
        .rst         (rst),
        .scl_i       (scl_m),
        .sda_i       (sda_line),
        .sda_oe      (sda_oe),
        .host_we     (host_we),
        .host_addr   (host_addr),
        .host_wdata  (host_wdata),
        .host_rdata  (host_rdata),
        .bus_wr      (bus_wr),
        .bus_wr_addr (bus_wr_addr),
        .bus_wr_data (bus_wr_data),
        .busy        (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Every high cycle of bus_wr consumes one expected commit
    always @(negedge clk) begin
        if (!rst && bus_wr) begin
            n_vec++;
            assert (exp_q.size() != 0) else begin
                n_err++;
                $error("FAIL bus_wr_unexpected: observed %0h expected none", {bus_wr_addr, bus_wr_data});
            end
            if (exp_q.size() != 0) check("bus_wr", {bus_wr_addr, bus_wr_data}, exp_q.pop_front());
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic wclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; wclk(Q);
        scl_m = 1'b1; wclk(Q);
        sda_m = 1'b0; wclk(Q);
        scl_m = 1'b0; wclk(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wclk(Q);
        scl_m = 1'b1; wclk(Q);
        sda_m = 1'b1; wclk(Q);
    endtask

    task automatic write_bit(input logic b);
        sda_m = b;    wclk(Q);
        scl_m = 1'b1; wclk(2 * Q);
        scl_m = 1'b0; wclk(Q);
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1; wclk(Q);
        scl_m = 1'b1; wclk(Q);
        b = sda_line; wclk(Q);
        scl_m = 1'b0; wclk(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        for (int i = 7; i >= 0; i--) read_bit(d[i]);
        write_bit(nack);
    endtask

    task automatic host_write(input logic [3:0] a, input logic [7:0] d);
        host_addr = a; host_wdata = d; host_we = 1'b1;
        wclk(1);
        host_we = 1'b0;
    endtask

    task automatic host_peek(input string tag, input logic [3:0] a, input logic [7:0] exp);
        host_addr = a;
        wclk(1);
        check(tag, host_rdata, exp);
    endtask

    initial begin
        logic       ack;
        logic [7:0] rd;
        logic       inc;
`ifdef I2C_SLAVE_AUTOINC_EN
        inc = 1'b1;
`else
        inc = 1'b0;
`endif
        wclk(3);
        check("rst_sda_oe", sda_oe, 0);
        check("rst_bus_wr", bus_wr, 0);
        check("rst_wr_addr", bus_wr_addr, 0);
        check("rst_wr_data", bus_wr_data, 0);
        check("rst_busy", busy, 0);
        check("rst_host_rdata", host_rdata, 0);
        rst = 1'b0;
        wclk(4);

        // Pointer write, repeated START, single read
        host_write(4'd6, 8'hA5);
        host_peek("preload6", 4'd6, 8'hA5);
        i2c_start();
        write_byte(8'h20, ack); check("t1_addr_ack", ack, 0);
        write_byte(8'h06, ack); check("t1_ptr_ack", ack, 0);
        i2c_start();
        write_byte(8'h21, ack); check("t1_raddr_ack", ack, 0);
        read_byte(1'b1, rd);    check("t1_rdata", rd, 8'hA5);
        check("t1_busy_hi", busy, 1);
        i2c_stop();
        wclk(6);
        check("t1_busy_lo", busy, 0);

        // Two data bytes
        i2c_start();
        write_byte(8'h20, ack); check("t2_addr_ack", ack, 0);
        write_byte(8'h03, ack); check("t2_ptr_ack", ack, 0);
        exp_q.push_back({4'd3, 8'h11});
        write_byte(8'h11, ack); check("t2_d0_ack", ack, 0);
        exp_q.push_back({(inc ? 4'd4 : 4'd3), 8'h22});
        write_byte(8'h22, ack); check("t2_d1_ack", ack, 0);
        i2c_stop();
        wclk(6);
        host_peek("t2_mem3", 4'd3, inc ? 8'h11 : 8'h22);
        host_peek("t2_mem4", 4'd4, inc ? 8'h22 : 8'h00);

        // Foreign address is not acknowledged
        i2c_start();
        write_byte(8'h40, ack); check("t3_nack", ack, 1);
        check("t3_busy", busy, 0);
        check("t3_sda_oe", sda_oe, 0);
        i2c_stop();
        wclk(6);

        // Pointer wrap
        i2c_start();
        write_byte(8'h20, ack); check("t4_addr_ack", ack, 0);
        write_byte(8'h0F, ack); check("t4_ptr_ack", ack, 0);
        exp_q.push_back({4'hF, 8'hAA});
        write_byte(8'hAA, ack);
        exp_q.push_back({(inc ? 4'h0 : 4'hF), 8'hBB});
        write_byte(8'hBB, ack);
        i2c_stop();
        wclk(6);
        host_peek("t4_mem15", 4'hF, inc ? 8'hAA : 8'hBB);
        host_peek("t4_mem0", 4'h0, inc ? 8'hBB : 8'h00);

        // STOP in the middle of a data byte
        i2c_start();
        write_byte(8'h20, ack);
        write_byte(8'h05, ack);
        for (int i = 0; i < 4; i++) write_bit(1'b1);
        i2c_stop();
        wclk(6);
        host_peek("t5_mem5", 4'd5, 8'h00);
        check("t5_sda_oe", sda_oe, 0);
        check("t5_busy", busy, 0);

        // Reset while the address ACK is being driven
        i2c_start();
        for (int i = 7; i >= 0; i--) write_bit(((8'h20 >> i) & 1) != 0);
        check("t6_ack_driven", sda_oe, 1);
        rst = 1'b1;
        #1;
        check("t6_async_release", sda_oe, 0);
        wclk(2);
        check("t6_busy", busy, 0);
        check("t6_wr_addr", bus_wr_addr, 0);
        check("t6_wr_data", bus_wr_data, 0);
        host_peek("t6_mem15", 4'hF, 8'h00);
        scl_m = 1'b1; sda_m = 1'b1;
        wclk(4);
        rst = 1'b0;
        wclk(4);
        i2c_start();
        write_byte(8'h20, ack); check("t6_addr_ack", ack, 0);
        write_byte(8'h02, ack);
        exp_q.push_back({4'd2, 8'h5C});
        write_byte(8'h5C, ack); check("t6_d_ack", ack, 0);
        i2c_stop();
        wclk(6);
        host_peek("t6_mem2", 4'd2, 8'h5C);

        check("sb_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
